// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of the SDRAM controller's Avalon-MM slave.
// Port A has priority; port C is forced through after STARVE_LIMIT A grants; read data is routed back in order.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 25,
  parameter int MAX_PEND     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [15:0]       a_writedata,
  input  logic [1:0]        a_byteenable,
  output logic              a_waitrequest,
  output logic [15:0]       a_readdata,
  output logic              a_readdatavalid,
  input  logic [ADDR_W-1:0] c_address,
  input  logic              c_read,
  input  logic              c_write,
  input  logic [15:0]       c_writedata,
  input  logic [1:0]        c_byteenable,
  output logic              c_waitrequest,
  output logic [15:0]       c_readdata,
  output logic              c_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [15:0]       m_writedata,
  output logic [1:0]        m_byteenable,
  input  logic              m_waitrequest,
  input  logic [15:0]       m_readdata,
  input  logic              m_readdatavalid
);
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] PEND_MAX   = CW'(MAX_PEND);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_C} state_t;
  state_t state, state_nxt;

  logic [MAX_PEND-1:0] id_fifo;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       pending;
  logic [SW-1:0]       starve;
  logic pend_ok, a_elig, c_elig, c_req, pick_a, pick_c;
  logic acc_a, acc_c, push, pop;

  // A read can only be granted while an ID slot is free; writes are untracked.
  assign pend_ok = (pending < PEND_MAX);
  assign a_elig  = a_read ? pend_ok : a_write;
  assign c_elig  = c_read ? pend_ok : c_write;
  assign c_req   = c_read | c_write;
  assign pick_c  = c_elig && (!a_elig || starve == STARVE_MAX);
  assign pick_a  = a_elig && !pick_c;
  assign push    = (acc_a | acc_c) & m_read;
  assign pop     = m_readdatavalid && (pending != '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    a_waitrequest = 1'b1;
    c_waitrequest = 1'b1;
    acc_a         = 1'b0;
    acc_c         = 1'b0;
    case (state)
      IDLE: begin
        if (pick_c)      state_nxt = GRANT_C;
        else if (pick_a) state_nxt = GRANT_A;
      end
      GRANT_A: begin
        a_waitrequest = m_waitrequest;
        acc_a         = !m_waitrequest;
        if (!m_waitrequest) state_nxt = IDLE;
      end
      GRANT_C: begin
        c_waitrequest = m_waitrequest;
        acc_c         = !m_waitrequest;
        if (!m_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command register; read wins if a port asserts read and write together.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      m_address    <= '0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else if (state == IDLE) begin
      if (pick_c) begin
        m_address    <= c_address;
        m_read       <= c_read;
        m_write      <= c_write & ~c_read;
        m_writedata  <= c_writedata;
        m_byteenable <= c_byteenable;
      end else if (pick_a) begin
        m_address    <= a_address;
        m_read       <= a_read;
        m_write      <= a_write & ~a_read;
        m_writedata  <= a_writedata;
        m_byteenable <= a_byteenable;
      end
    end else if (acc_a | acc_c) begin
      m_read  <= 1'b0;
      m_write <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n)                      starve <= '0;
    else if (!c_req || acc_c)                starve <= '0;
    else if (acc_a && starve != STARVE_MAX)  starve <= starve + 1'b1;
  end

  // Read-ID FIFO: one bit per outstanding read, 0 = A, 1 = C.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      id_fifo <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        id_fifo[wr_ptr] <= acc_c;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Stray read data with no tracked ID is discarded.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      a_readdata      <= '0;
      a_readdatavalid <= 1'b0;
      c_readdata      <= '0;
      c_readdatavalid <= 1'b0;
    end else begin
      a_readdatavalid <= pop & ~id_fifo[rd_ptr];
      c_readdatavalid <= pop &  id_fifo[rd_ptr];
      if (pop && !id_fifo[rd_ptr]) a_readdata <= m_readdata;
      if (pop &&  id_fifo[rd_ptr]) c_readdata <= m_readdata;
    end
  end
endmodule
